id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 14 +
 rtl/id_ex_stage_alu_ctrl_dec.sv | 20 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU op codes, ALUOp classes and funct3 values shared by the ID/EX stage and the ALU-control decoder
package id_ex_stage_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOP = 4'b1111;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU-control decode
//   i_alu_op (2), i_funct3 (3), i_funct7b5, i_is_rtype -> o_alu_ctrl (4)
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output logic [3:0] o_alu_ctrl
);
  logic [3:0] w_arith;
  // funct7b5 only selects sub for R-type; addi has imm[10] in that bit
  assign w_arith = (i_funct3 == F3_ADD) ? ((i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD) :
                   (i_funct3 == F3_AND) ? ALU_AND :
                   (i_funct3 == F3_OR)  ? ALU_OR  : ALU_NOP;
  assign o_alu_ctrl = (i_alu_op == ALUOP_MEM)   ? ALU_ADD :
                      (i_alu_op == ALUOP_BR)    ? ALU_SUB :
                      (i_alu_op == ALUOP_ARITH) ? w_arith : ALU_NOP;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode, load-use detection and bubble counter
//   in : clk, rst_n, id_* decoded fields/control, stall_i (hold), flush_i (bubble)
//   out: ex_* latched fields/control, alu_a_o/alu_b_o/alu_ctrl_o, load_use_o, bubble_cnt_o
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RADDR-1:0] id_rs1_i,
  input  logic [RADDR-1:0] id_rs2_i,
  input  logic [RADDR-1:0] id_rd_i,
  input  logic [2:0]       id_funct3_i,
  input  logic             id_funct7b5_i,
  input  logic [1:0]       id_alu_op_i,
  input  logic             id_alu_src_i,
  input  logic             id_is_rtype_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_to_reg_i,
  input  logic             id_branch_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [RADDR-1:0] ex_rd_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_to_reg_o,
  output logic             ex_branch_o,
  output logic             load_use_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  logic [3:0]       w_alu_ctrl;
  logic             r_valid;
  logic [XLEN-1:0]  r_pc, r_a, r_b, r_rs2_data;
  logic [3:0]       r_alu_ctrl;
  logic [RADDR-1:0] r_rd;
  logic [4:0]       r_ctl;
  logic [CNT_W-1:0] r_bubble_cnt;

  alu_ctrl_dec u_dec (
    .i_alu_op   (id_alu_op_i),
    .i_funct3   (id_funct3_i),
    .i_funct7b5 (id_funct7b5_i),
    .i_is_rtype (id_is_rtype_i),
    .o_alu_ctrl (w_alu_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rs2_data   <= '0;
      r_alu_ctrl   <= '0;
      r_rd         <= '0;
      r_ctl        <= '0;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rs2_data   <= '0;
      r_alu_ctrl   <= '0;
      r_rd         <= '0;
      r_ctl        <= '0;
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else if (!stall_i) begin
      r_valid      <= id_valid_i;
      r_pc         <= id_pc_i;
      r_a          <= id_rs1_data_i;
      r_b          <= id_alu_src_i ? id_imm_i : id_rs2_data_i;
      r_rs2_data   <= id_rs2_data_i;
      r_alu_ctrl   <= w_alu_ctrl;
      r_rd         <= id_rd_i;
      r_ctl        <= {id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i};
    end
  end

  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign alu_a_o         = r_a;
  assign alu_b_o         = r_b;
  assign alu_ctrl_o      = r_alu_ctrl;
  assign ex_rs2_data_o   = r_rs2_data;
  assign ex_rd_o         = r_rd;
  assign {ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o} = r_ctl;
  assign bubble_cnt_o    = r_bubble_cnt;
  // x0 is never a real dependency, so a load into x0 raises no hazard
  assign load_use_o = r_valid && r_ctl[4] && (r_rd != '0) && id_valid_i &&
                      ((r_rd == id_rs1_i) || ((r_rd == id_rs2_i) && id_uses_rs2_i));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage (4-bit bubble counter to exercise wrap)
module tb_id_ex_stage;
  localparam int XLEN = 32, RADDR = 5, CNT_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid_i, id_alu_src_i, id_is_rtype_i, id_uses_rs2_i, id_funct7b5_i;
  logic [XLEN-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [RADDR-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0] id_funct3_i;
  logic [1:0] id_alu_op_i;
  logic id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i;
  logic stall_i, flush_i;
  logic ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o, load_use_o;
  logic [XLEN-1:0] ex_pc_o, alu_a_o, alu_b_o, ex_rs2_data_o;
  logic [3:0] alu_ctrl_o;
  logic [RADDR-1:0] ex_rd_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [4:0] ctl;
  logic [147:0] all_out;
  int n_vec = 0, n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  assign ctl = {ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o};
  assign all_out = {ex_valid_o, ex_pc_o, alu_a_o, alu_b_o, alu_ctrl_o, ex_rs2_data_o, ex_rd_o, ctl, load_use_o, bubble_cnt_o};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_funct3_i(id_funct3_i),
    .id_funct7b5_i(id_funct7b5_i), .id_alu_op_i(id_alu_op_i), .id_alu_src_i(id_alu_src_i),
    .id_is_rtype_i(id_is_rtype_i), .id_uses_rs2_i(id_uses_rs2_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .id_branch_i(id_branch_i), .stall_i(stall_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_ctrl_o(alu_ctrl_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_o(ex_rd_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_branch_o(ex_branch_o), .load_use_o(load_use_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    {id_valid_i, id_alu_src_i, id_is_rtype_i, id_uses_rs2_i, id_funct7b5_i} = '0;
    {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i} = '0;
    {id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_alu_op_i} = '0;
    {id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i} = '0;
    {stall_i, flush_i} = '0;
  endtask

  task automatic load_full();
    id_valid_i = 1; id_pc_i = 32'h1234; id_rs1_data_i = 32'hAAAA; id_rs2_data_i = 32'h5555;
    id_imm_i = 32'h10; id_alu_src_i = 0; id_rd_i = 5'd9; id_alu_op_i = 2'b10; id_funct3_i = 3'b000;
    id_funct7b5_i = 1; id_is_rtype_i = 1;
    {id_mem_read_i, id_mem_write_i, id_reg_write_i, id_mem_to_reg_i, id_branch_i} = 5'b11111;
  endtask

  task automatic check_full(input string tag);
    n_vec++;
    if ({ex_valid_o, ex_pc_o, alu_a_o, alu_b_o, alu_ctrl_o, ex_rs2_data_o, ex_rd_o, ctl} !==
        {1'b1, 32'h1234, 32'hAAAA, 32'h5555, 4'b0110, 32'h5555, 5'd9, 5'b11111}) begin
      $display("FAIL %s: got v=%b pc=%h a=%h b=%h ctrl=%b rs2d=%h rd=%0d ctl=%b, want v=1 pc=1234 a=aaaa b=5555 ctrl=0110 rs2d=5555 rd=9 ctl=11111",
               tag, ex_valid_o, ex_pc_o, alu_a_o, alu_b_o, alu_ctrl_o, ex_rs2_data_o, ex_rd_o, ctl);
      n_err++;
    end
  endtask

  task automatic test_reset();
    id_clear();
    tick(); tick();
    n_vec++;
    if (all_out !== '0) begin $display("FAIL reset_state: got %h want 0", all_out); n_err++; end
    rst_n = 1;
    load_full();
    tick();
    check_full("load_after_first_release");
    stall_i = 1;
    id_pc_i = 32'hDEAD;
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (all_out !== '0) begin $display("FAIL async_reset_mid_stall: got %h want 0", all_out); n_err++; end
    tick();
    rst_n = 1;
    stall_i = 0;
    id_pc_i = 32'h1234;
    exp_cnt = '0;
    tick();
    check_full("load_after_reset_release");
  endtask

  task automatic test_decode();
    logic [1:0] ops [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10};
    logic [2:0] f3s [9] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 3'b000, 3'b111, 3'b001, 3'b000};
    logic f7s [9] = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
    logic rts [9] = '{1, 0, 1, 1, 0, 0, 1, 1, 1};
    logic [3:0] exps [9] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0110, 4'b1111, 4'b0010, 4'b1111, 4'b0010};
    id_clear();
    id_valid_i = 1;
    for (int i = 0; i < 9; i++) begin
      id_alu_op_i = ops[i]; id_funct3_i = f3s[i]; id_funct7b5_i = f7s[i]; id_is_rtype_i = rts[i];
      tick();
      n_vec++;
      if (alu_ctrl_o !== exps[i]) begin
        $display("FAIL decode[%0d]: alu_ctrl got %b want %b", i, alu_ctrl_o, exps[i]); n_err++;
      end
    end
  endtask

  task automatic test_operand_select();
    id_clear();
    id_valid_i = 1; id_rs2_data_i = 32'h0000_0005; id_imm_i = 32'hFFFF_FFFC; id_alu_src_i = 1;
    tick();
    n_vec++;
    if ({alu_b_o, ex_rs2_data_o} !== {32'hFFFF_FFFC, 32'h0000_0005}) begin
      $display("FAIL opsel_imm: got b=%h rs2d=%h want b=fffffffc rs2d=00000005", alu_b_o, ex_rs2_data_o); n_err++;
    end
    id_alu_src_i = 0;
    tick();
    n_vec++;
    if ({alu_b_o, ex_rs2_data_o} !== {32'h0000_0005, 32'h0000_0005}) begin
      $display("FAIL opsel_reg: got b=%h rs2d=%h want b=00000005 rs2d=00000005", alu_b_o, ex_rs2_data_o); n_err++;
    end
  endtask

  task automatic test_load_use();
    id_clear();
    id_valid_i = 1; id_mem_read_i = 1; id_rd_i = 5'd7; id_alu_op_i = 2'b00;
    tick();
    id_clear();
    id_valid_i = 1; id_rs1_i = 5'd7;
    #1; n_vec++;
    if (load_use_o !== 1'b1) begin $display("FAIL lu_rs1: got %b want 1", load_use_o); n_err++; end
    id_rs1_i = 5'd0; id_rs2_i = 5'd7; id_uses_rs2_i = 0;
    #1; n_vec++;
    if (load_use_o !== 1'b0) begin $display("FAIL lu_rs2_unused: got %b want 0", load_use_o); n_err++; end
    id_uses_rs2_i = 1;
    #1; n_vec++;
    if (load_use_o !== 1'b1) begin $display("FAIL lu_rs2_used: got %b want 1", load_use_o); n_err++; end
    id_valid_i = 0;
    #1; n_vec++;
    if (load_use_o !== 1'b0) begin $display("FAIL lu_id_invalid: got %b want 0", load_use_o); n_err++; end
    id_clear();
    id_valid_i = 1; id_mem_read_i = 1; id_rd_i = 5'd0;
    tick();
    id_clear();
    id_valid_i = 1; id_uses_rs2_i = 1;
    #1; n_vec++;
    if (load_use_o !== 1'b0) begin $display("FAIL lu_rd_zero: got %b want 0", load_use_o); n_err++; end
    id_clear();
    id_valid_i = 1; id_rd_i = 5'd7; id_rs1_i = 5'd7;
    tick();
    #1; n_vec++;
    if (load_use_o !== 1'b0) begin $display("FAIL lu_not_load: got %b want 0", load_use_o); n_err++; end
  endtask

  task automatic test_stall_flush();
    id_clear();
    id_valid_i = 1; id_pc_i = 32'h100; id_rd_i = 5'd3; id_reg_write_i = 1; id_rs1_data_i = 32'h77;
    tick();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc_i = 32'h200 + i; id_rd_i = 5'd10 + 5'(i); id_reg_write_i = 0; id_valid_i = 0; id_rs1_data_i = 32'h99;
      tick();
      n_vec++;
      if ({ex_valid_o, ex_pc_o, ex_rd_o, ex_reg_write_o, alu_a_o} !== {1'b1, 32'h100, 5'd3, 1'b1, 32'h77}) begin
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h rd=%0d rw=%b a=%h want v=1 pc=100 rd=3 rw=1 a=77",
                 i, ex_valid_o, ex_pc_o, ex_rd_o, ex_reg_write_o, alu_a_o); n_err++;
      end
    end
    id_valid_i = 1; id_reg_write_i = 1; id_mem_read_i = 1; id_alu_op_i = 2'b01;
    flush_i = 1;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if ({ex_valid_o, ctl, ex_pc_o, alu_ctrl_o, ex_rd_o, alu_a_o} !== '0 || bubble_cnt_o !== exp_cnt) begin
      $display("FAIL stall_flush_bubble: got v=%b ctl=%b pc=%h ctrl=%b rd=%0d a=%h cnt=%0d want all 0 cnt=%0d",
               ex_valid_o, ctl, ex_pc_o, alu_ctrl_o, ex_rd_o, alu_a_o, bubble_cnt_o, exp_cnt); n_err++;
    end
    stall_i = 0; id_valid_i = 0;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    n_vec++;
    if (bubble_cnt_o !== exp_cnt) begin
      $display("FAIL flush_invalid_counts: got %0d want %0d", bubble_cnt_o, exp_cnt); n_err++;
    end
    flush_i = 0;
    tick();
    n_vec++;
    if (bubble_cnt_o !== exp_cnt) begin
      $display("FAIL no_flush_no_count: got %0d want %0d", bubble_cnt_o, exp_cnt); n_err++;
    end
  endtask

  task automatic test_counter_wrap();
    id_clear();
    rst_n = 0;
    #1 rst_n = 1;
    flush_i = 1;
    for (int i = 0; i < 15; i++) tick();
    n_vec++;
    if (bubble_cnt_o !== 4'd15) begin $display("FAIL cnt_15: got %0d want 15", bubble_cnt_o); n_err++; end
    tick();
    n_vec++;
    if (bubble_cnt_o !== 4'd0) begin $display("FAIL cnt_wrap: got %0d want 0", bubble_cnt_o); n_err++; end
    flush_i = 0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_operand_select();
    test_load_use();
    test_stall_flush();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
